// File: rtl/auto_parkcalc_hls_deadlock_reporter.sv
// Deadlock reporter for the auto_parkcalc HLS monitor tree: confirms a sustained block flag,
// snapshots raw block/idle vectors with a timestamp, and hands off one report word.
module auto_parkcalc_hls_deadlock_reporter #(
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned TS_W           = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              block_i,
    input  logic [2:0]        axis_block_sigs_i,
    input  logic [1:0]        inst_idle_sigs_i,
    input  logic [0:0]        inst_block_sigs_i,
    input  logic              enable_i,
    input  logic              clear_i,
    output logic              report_valid_o,
    input  logic              report_ready_i,
    output logic [TS_W+7:0]   report_data_o,
    output logic              deadlock_o,
    output logic [7:0]        report_count_o
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = TS_W + 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;
    localparam logic [1:0] S_LATCHED = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [TS_W-1:0]   ts_q,     ts_d;
    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              dl_q,     dl_d;
    logic [7:0]        count_q,  count_d;

    // Next-state: confirm window, snapshot on the final confirming edge, handshake, sticky latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q + TS_W'(1);
        valid_d = valid_q;
        data_d  = data_q;
        dl_d    = dl_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable_i && block_i) begin
                    state_d = S_CONFIRM;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_CONFIRM: begin
                if (!enable_i || !block_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = {ts_q, 1'b0, inst_idle_sigs_i, inst_block_sigs_i,
                               axis_block_sigs_i, 1'b1};
                    dl_d    = 1'b1;
                    valid_d = 1'b1;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Only the handshake can leave REPORT, so valid never drops early.
            S_REPORT: begin
                if (report_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_LATCHED;
                end
            end
            S_LATCHED: begin
                if (clear_i) begin
                    dl_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ts_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dl_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dl_q    <= dl_d;
            count_q <= count_d;
        end
    end

    assign report_valid_o = valid_q;
    assign report_data_o  = data_q;
    assign deadlock_o     = dl_q;
    assign report_count_o = count_q;

endmodule

// File: tb/tb_auto_parkcalc_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter; report words are predicted into a queue at stimulus
// time and checked when report_valid rises.
module tb_auto_parkcalc_hls_deadlock_reporter;

    localparam int unsigned CONF = 4;
    localparam int unsigned TSW  = 16;
    localparam int unsigned DW   = TSW + 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          block = 1'b0;
    logic [2:0]    axis = 3'b000;
    logic [1:0]    idle = 2'b00;
    logic [0:0]    iblock = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          ready = 1'b0;
    logic          report_valid;
    logic [DW-1:0] report_data;
    logic          deadlock;
    logic [7:0]    report_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [TSW-1:0] m_ts;
    logic [DW-1:0]  sb[$];
    logic [DW-1:0]  mon_exp;
    logic [DW-1:0]  held;
    logic           prev_valid = 1'b0;

    always #5 clk = ~clk;

    auto_parkcalc_hls_deadlock_reporter #(
        .CONFIRM_CYCLES(CONF),
        .TS_W(TSW)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .block_i(block),
        .axis_block_sigs_i(axis),
        .inst_idle_sigs_i(idle),
        .inst_block_sigs_i(iblock),
        .enable_i(enable),
        .clear_i(clear),
        .report_valid_o(report_valid),
        .report_ready_i(ready),
        .report_data_o(report_data),
        .deadlock_o(deadlock),
        .report_count_o(report_count)
    );

    // Reference timestamp: counts clock edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) m_ts <= '0;
        else     m_ts <= m_ts + TSW'(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Snapshot lands CONF-1 edges after the first high sample driven now.
    task automatic push_exp();
        logic [TSW-1:0] t;
        t = m_ts + TSW'(CONF - 1);
        sb.push_back({t, 1'b0, idle, iblock, axis, 1'b1});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (report_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_report", 64'd1, 64'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("report_data", 64'(report_data), 64'(mon_exp));
                end
            end
            prev_valid = report_valid;
        end
    end

    initial begin
        step(2);
        chk("rst_valid", 64'(report_valid), 64'd0);
        chk("rst_deadlock", 64'(deadlock), 64'd0);
        chk("rst_count", 64'(report_count), 64'd0);
        chk("rst_data", 64'(report_data), 64'd0);

        // Basic confirm: ts snapshot is 3 with block high from the first edge.
        rst = 1'b0; enable = 1'b1; block = 1'b1; axis = 3'b101; ready = 1'b1;
        push_exp();
        chk("basic_model_ts", 64'(sb[0]), 64'({16'd3, 1'b0, 2'b00, 1'b0, 3'b101, 1'b1}));
        step(3);
        chk("basic_not_early", 64'(report_valid), 64'd0);
        step(1);
        chk("basic_valid", 64'(report_valid), 64'd1);
        chk("basic_deadlock", 64'(deadlock), 64'd1);
        chk("basic_count", 64'(report_count), 64'd1);
        step(1);
        chk("basic_valid_1cyc", 64'(report_valid), 64'd0);
        chk("basic_latched", 64'(deadlock), 64'd1);

        // Clear with block still high re-arms a full confirm window.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_deadlock", 64'(deadlock), 64'd0);
        push_exp();
        step(3);
        chk("rearm_not_early", 64'(report_valid), 64'd0);
        step(1);
        chk("rearm_valid", 64'(report_valid), 64'd1);
        chk("rearm_count", 64'(report_count), 64'd2);
        step(1);
        block = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear2_deadlock", 64'(deadlock), 64'd0);

        // Glitch: low sample right before the confirming edge aborts.
        axis = 3'b010; idle = 2'b11; iblock = 1'b1;
        block = 1'b1;
        step(3);
        block = 1'b0;
        step(1);
        chk("glitch_no_valid", 64'(report_valid), 64'd0);
        chk("glitch_no_deadlock", 64'(deadlock), 64'd0);
        block = 1'b1;
        push_exp();
        step(3);
        chk("glitch_not_early", 64'(report_valid), 64'd0);
        step(1);
        chk("glitch_valid", 64'(report_valid), 64'd1);
        chk("glitch_count", 64'(report_count), 64'd3);
        step(1);
        block = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0;

        // Backpressure: valid/data hold while block and clear toggle.
        axis = 3'b111; idle = 2'b01; iblock = 1'b0; ready = 1'b0; block = 1'b1;
        push_exp();
        held = sb[0];
        step(4);
        chk("bp_valid", 64'(report_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            block = i[0];
            clear = ~i[0];
            axis  = 3'(i);
            step(1);
            chk("bp_valid_hold", 64'(report_valid), 64'd1);
            chk("bp_data_hold", 64'(report_data), 64'(held));
        end
        clear = 1'b1; ready = 1'b1; block = 1'b1;
        step(1);
        chk("bp_valid_drop", 64'(report_valid), 64'd0);
        chk("bp_simul_deadlock", 64'(deadlock), 64'd1);
        clear = 1'b0; block = 1'b0;
        step(2);
        chk("bp_sticky", 64'(deadlock), 64'd1);
        chk("bp_data_kept", 64'(report_data), 64'(held));
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("bp_cleared", 64'(deadlock), 64'd0);
        chk("bp_count", 64'(report_count), 64'd4);

        // Enable gating.
        enable = 1'b0; block = 1'b1;
        step(100);
        chk("en_off_valid", 64'(report_valid), 64'd0);
        chk("en_off_deadlock", 64'(deadlock), 64'd0);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(1);
        enable = 1'b1; block = 1'b0;
        step(5);
        chk("en_drop_deadlock", 64'(deadlock), 64'd0);
        chk("en_drop_count", 64'(report_count), 64'd4);

        // Asynchronous reset while a report is pending.
        ready = 1'b0; block = 1'b1;
        push_exp();
        step(4);
        chk("pre_rst_valid", 64'(report_valid), 64'd1);
        chk("pre_rst_count", 64'(report_count), 64'd5);
        #1 rst = 1'b1;
        #1;
        chk("async_valid", 64'(report_valid), 64'd0);
        chk("async_deadlock", 64'(deadlock), 64'd0);
        chk("async_count", 64'(report_count), 64'd0);
        chk("async_data", 64'(report_data), 64'd0);
        block = 1'b0; ready = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        chk("no_replay", 64'(report_valid), 64'd0);

        // Saturation over 300 deadlock/clear rounds.
        for (int i = 0; i < 300; i++) begin
            axis   = 3'($urandom_range(7));
            idle   = 2'($urandom_range(3));
            iblock = 1'($urandom_range(1));
            block  = 1'b1;
            push_exp();
            step(4);
            chk("sat_valid", 64'(report_valid), 64'd1);
            chk("sat_count", 64'(report_count), 64'((i + 1 > 255) ? 255 : i + 1));
            step(1);
            block = 1'b0; clear = 1'b1;
            step(1);
            clear = 1'b0;
        end
        step(2);
        chk("sat_final", 64'(report_count), 64'd255);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
